// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, PC step,
// fetch FSM encodings and enable levels.
package inst_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MISS = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped, one-word-per-line instruction cache with a combinational read
// port and a synchronous fill port; valid bits clear on reset.
module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter int ICACHE_LINES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-3:0] rd_word,
  output logic              hit,
  output logic [INST_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-3:0] wr_word,
  input  logic [INST_W-1:0] wr_data
);

  localparam int IDX   = $clog2(ICACHE_LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX;

  logic [ICACHE_LINES-1:0] valid_reg;
  logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
  logic [INST_W-1:0]       data_mem [ICACHE_LINES];

  logic [IDX-1:0] rd_idx;
  logic [IDX-1:0] wr_idx;

  assign rd_idx  = rd_word[IDX-1:0];
  assign wr_idx  = wr_word[IDX-1:0];
  assign hit     = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_word[ADDR_W-3:IDX]);
  assign rd_data = data_mem[rd_idx];

  // Tag/data carry no reset so they map onto plain memory; only valid bits clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_word[ADDR_W-3:IDX];
      data_mem[wr_idx] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < ICACHE_LINES; gi++) begin : g_valid
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg[gi] <= 1'b0;
      end else if (wr_en && (wr_idx == IDX'(gi))) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, miss handling towards memctrl, issue to decoder.
// Define ICACHE_EN to include the direct-mapped instruction cache.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          ICACHE_LINES = 64,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              oMC_en,
  output logic [ADDR_W-1:0] oMC_addr,
  input  logic              iMC_done,
  input  logic [INST_W-1:0] iMC_inst,
  output logic              oID_en,
  output logic [INST_W-1:0] oID_inst,
  output logic [ADDR_W-1:0] oID_pc,
  input  logic              iID_stall,
  input  logic              iROB_jump_en,
  input  logic [ADDR_W-1:0] iROB_jump_pc
);

  logic [ADDR_W-1:0] pc_reg;
  logic [1:0]        state_reg;
  logic              discard_reg;
  logic              mc_en_reg;
  logic [ADDR_W-1:0] mc_addr_reg;
  logic              id_en_reg;
  logic [INST_W-1:0] id_inst_reg;
  logic [ADDR_W-1:0] id_pc_reg;
  logic [INST_W-1:0] hold_inst_reg;

  logic              cache_hit;
  logic [INST_W-1:0] cache_data;

`ifdef ICACHE_EN
  logic fill_en;

  // The fill lands at the requested address even when the fetch was redirected.
  assign fill_en = rdy && (state_reg == S_MISS) && iMC_done;

  inst_fetch_icache #(
    .ICACHE_LINES(ICACHE_LINES)
  ) u_icache (
    .clk    (clk),
    .rst    (rst),
    .rd_word(pc_reg[ADDR_W-1:2]),
    .hit    (cache_hit),
    .rd_data(cache_data),
    .wr_en  (fill_en),
    .wr_word(mc_addr_reg[ADDR_W-1:2]),
    .wr_data(iMC_inst)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg        <= RESET_PC;
      state_reg     <= S_IDLE;
      discard_reg   <= DISABLE;
      mc_en_reg     <= DISABLE;
      mc_addr_reg   <= '0;
      id_en_reg     <= DISABLE;
      id_inst_reg   <= '0;
      id_pc_reg     <= '0;
      hold_inst_reg <= '0;
    end else if (rdy) begin
      if (iROB_jump_en) begin
        pc_reg    <= iROB_jump_pc;
        id_en_reg <= DISABLE;
        // An in-flight request cannot be aborted: remember to drop its result.
        if ((state_reg == S_MISS) && !iMC_done) begin
          discard_reg <= ENABLE;
        end else begin
          state_reg   <= S_IDLE;
          discard_reg <= DISABLE;
          mc_en_reg   <= DISABLE;
        end
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (iID_stall) begin
              id_en_reg <= DISABLE;
            end else if (cache_hit) begin
              id_en_reg   <= ENABLE;
              id_inst_reg <= cache_data;
              id_pc_reg   <= pc_reg;
              pc_reg      <= pc_reg + PC_STEP;
            end else begin
              id_en_reg   <= DISABLE;
              mc_en_reg   <= ENABLE;
              mc_addr_reg <= pc_reg;
              state_reg   <= S_MISS;
            end
          end
          S_MISS: begin
            id_en_reg <= DISABLE;
            if (iMC_done) begin
              mc_en_reg <= DISABLE;
              if (discard_reg) begin
                discard_reg <= DISABLE;
                state_reg   <= S_IDLE;
              end else if (!iID_stall) begin
                id_en_reg   <= ENABLE;
                id_inst_reg <= iMC_inst;
                id_pc_reg   <= pc_reg;
                pc_reg      <= pc_reg + PC_STEP;
                state_reg   <= S_IDLE;
              end else begin
                hold_inst_reg <= iMC_inst;
                state_reg     <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!iID_stall) begin
              id_en_reg   <= ENABLE;
              id_inst_reg <= hold_inst_reg;
              id_pc_reg   <= pc_reg;
              pc_reg      <= pc_reg + PC_STEP;
              state_reg   <= S_IDLE;
            end else begin
              id_en_reg <= DISABLE;
            end
          end
          default: begin
            id_en_reg <= DISABLE;
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign oMC_en   = mc_en_reg;
  assign oMC_addr = mc_addr_reg;
  assign oID_en   = id_en_reg;
  assign oID_inst = id_inst_reg;
  assign oID_pc   = id_pc_reg;

endmodule
